// File: rtl/base_arb_pkg.sv
// -----------------------------------------------------------------------------
// base_arb_pkg
//   Shared definitions for the round-robin arbiter family.
//   - arb_state_e : arbiter FSM state (IDLE / HOLD)
//   - rr_wrap_inc : next round-robin index, wrapping at the requester count
// -----------------------------------------------------------------------------
package base_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } arb_state_e;

  // Index following idx in a ring of n requesters. idx is always < n, so
  // a compare-and-reset is enough and no divider is needed.
  function automatic int unsigned rr_wrap_inc(input int unsigned idx,
                                              input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage : base_arb_pkg

// File: rtl/base_rr_onehot.sv
// -----------------------------------------------------------------------------
// base_rr_onehot
//   Binary-to-one-hot decoder with enable. The output is all-zero when en is
//   low, so at most one bit is ever set.
//
//   Parameters:
//     width        number of one-hot output bits
//     index_width  width of the binary index
//   Ports:
//     en      input   enable; forces output to zero when low
//     index   input   binary index to decode
//     onehot  output  decoded one-hot vector
// -----------------------------------------------------------------------------
module base_rr_onehot
  import base_arb_pkg::*;
#(
  parameter int width       = 4,
  parameter int index_width = 2
) (
  input  logic                   en,
  input  logic [index_width-1:0] index,
  output logic [width-1:0]       onehot
);

  for (genvar gi = 0; gi < width; gi++) begin : g_dec
    assign onehot[gi] = en && (index == index_width'(gi));
  end

endmodule : base_rr_onehot

// File: rtl/base_rr_arb.sv
// -----------------------------------------------------------------------------
// base_rr_arb
//   Round-robin arbiter with one-cycle grant latency. In IDLE the first
//   requesting index at or above the rotating pointer is granted on the next
//   edge; the grant is then held (HOLD) for as long as that requester keeps
//   its request up. On release the pointer moves to the index just above the
//   last grantee, and there is always one IDLE cycle between two grants.
//
//   Parameters:
//     enc_width       width of the encoded grant index
//     req_width       number of requesters (1 .. 2**enc_width)
//     timeout_cycles  maximum grant hold length (timeout build only)
//   Ports:
//     clk        input   clock, rising edge
//     reset      input   asynchronous active-high reset
//     req        input   level request per requester
//     grant      output  one-hot grant, zero when nothing is granted
//     grant_v    output  a grant is active
//     grant_enc  output  binary index of the grantee (valid with grant_v)
//     timeout    output  one-cycle pulse when a grant was cut short
//                        (only when BASE_RR_ARB_TIMEOUT_EN is defined)
//
//   Build option:
//     BASE_RR_ARB_TIMEOUT_EN  adds the hold counter and the timeout port.
//                             Without it a grant lasts until req drops.
// -----------------------------------------------------------------------------
module base_rr_arb
  import base_arb_pkg::*;
#(
  parameter int enc_width      = 2,
  parameter int req_width      = 2**enc_width,
  parameter int timeout_cycles = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [req_width-1:0] req,
  output logic [req_width-1:0] grant,
  output logic                 grant_v,
  output logic [enc_width-1:0] grant_enc
`ifdef BASE_RR_ARB_TIMEOUT_EN
  ,
  output logic                 timeout
`endif
);

  // Catch impossible configurations at elaboration rather than in the lab.
  if (req_width < 1 || req_width > (1 << enc_width) || timeout_cycles < 1)
  begin : g_param_check
    $error("base_rr_arb: illegal enc_width/req_width/timeout_cycles");
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  arb_state_e           state_q, state_d;
  logic [enc_width-1:0] ptr_q, ptr_d;
  logic [enc_width-1:0] grant_enc_q, grant_enc_d;
  logic                 grant_v_q, grant_v_d;

  // Combinational search results
  logic [2*req_width-1:0] req_dbl;
  logic [req_width-1:0]   req_rot;
  logic                   sel_found;
  logic [enc_width-1:0]   sel_idx;

  // Hold tracking
  logic                   held;
  logic                   release_hold;
  logic [enc_width-1:0]   ptr_after_grant;

`ifdef BASE_RR_ARB_TIMEOUT_EN
  localparam int cnt_w = $clog2(timeout_cycles + 1);
  localparam logic [cnt_w-1:0] cnt_last = cnt_w'(timeout_cycles - 1);

  logic [cnt_w-1:0] hold_cnt_q, hold_cnt_d;
  logic             timeout_q, timeout_d;
  logic             timeout_hit;
`endif

  // ---------------------------------------------------------------------------
  // Grant decode: grant is derived from the registered index so it can never
  // disagree with grant_enc or carry more than one bit.
  // ---------------------------------------------------------------------------
  base_rr_onehot #(
    .width       (req_width),
    .index_width (enc_width)
  ) u_onehot (
    .en     (grant_v_q),
    .index  (grant_enc_q),
    .onehot (grant)
  );

  assign grant_v   = grant_v_q;
  assign grant_enc = grant_enc_q;

  // ---------------------------------------------------------------------------
  // Rotating priority search.
  // Concatenating req with itself and shifting right by ptr puts the pointer
  // position at bit 0, so a plain lowest-bit-first scan of req_rot walks the
  // ring upward from ptr and wraps at req_width-1. This also handles
  // non-power-of-two widths: the ring is exactly req_width long.
  // ---------------------------------------------------------------------------
  assign req_dbl = {req, req};
  assign req_rot = req_width'(req_dbl >> ptr_q);

  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = 0; i < req_width; i++) begin
      if (!sel_found && req_rot[i]) begin
        sel_found = 1'b1;
        // ptr + i < 2*req_width, so one conditional subtract restores range.
        sel_idx   = enc_width'((int'(ptr_q) + i >= req_width)
                               ? (int'(ptr_q) + i - req_width)
                               : (int'(ptr_q) + i));
      end
    end
  end

  // The grantee still wants the resource. grant is zero outside HOLD, so this
  // is only meaningful while holding.
  assign held = |(req & grant);

  assign ptr_after_grant = enc_width'(rr_wrap_inc(32'(grant_enc_q), req_width));

`ifdef BASE_RR_ARB_TIMEOUT_EN
  // Counter holds (number of HOLD cycles already completed); it equals
  // cnt_last during the timeout_cycles-th cycle of grant_v.
  assign timeout_hit  = (hold_cnt_q == cnt_last);
  assign release_hold = !held || timeout_hit;
  assign timeout      = timeout_q;
`else
  assign release_hold = !held;
`endif

  // ---------------------------------------------------------------------------
  // FSM: state register (all registers live here)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      grant_enc_q <= '0;
      grant_v_q   <= 1'b0;
`ifdef BASE_RR_ARB_TIMEOUT_EN
      hold_cnt_q  <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      grant_enc_q <= grant_enc_d;
      grant_v_q   <= grant_v_d;
`ifdef BASE_RR_ARB_TIMEOUT_EN
      hold_cnt_q  <= hold_cnt_d;
      timeout_q   <= timeout_d;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (sel_found)    state_d = HOLD;
      HOLD:    if (release_hold) state_d = IDLE;
      default:                   state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: output / datapath logic
  // Outputs are registered, so the values computed here appear one edge
  // later, which gives the one-cycle request-to-grant latency.
  // ---------------------------------------------------------------------------
  always_comb begin
    grant_enc_d = grant_enc_q;
    grant_v_d   = grant_v_q;
    ptr_d       = ptr_q;
`ifdef BASE_RR_ARB_TIMEOUT_EN
    hold_cnt_d  = hold_cnt_q;
    timeout_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (sel_found) begin
          grant_enc_d = sel_idx;
          grant_v_d   = 1'b1;
`ifdef BASE_RR_ARB_TIMEOUT_EN
          hold_cnt_d  = '0;
`endif
        end
      end
      HOLD: begin
        if (release_hold) begin
          grant_enc_d = '0;
          grant_v_d   = 1'b0;
          ptr_d       = ptr_after_grant;
`ifdef BASE_RR_ARB_TIMEOUT_EN
          // Still requested yet released: the counter forced it.
          timeout_d   = held;
`endif
        end else begin
`ifdef BASE_RR_ARB_TIMEOUT_EN
          hold_cnt_d  = hold_cnt_q + cnt_w'(1);
`endif
        end
      end
      default: begin
        grant_enc_d = '0;
        grant_v_d   = 1'b0;
      end
    endcase
  end

endmodule : base_rr_arb

// File: doc/base_rr_arb.md
BASE_RR_ARB -- requirements
Module: base_rr_arb

Interface
REQ-001 SHALL have parameter enc_width, default 2, the width of the encoded grant index.
REQ-002 SHALL have parameter req_width, default 2**enc_width, the number of requesters (1..2**enc_width).
REQ-003 SHALL have parameter timeout_cycles, default 16, the maximum number of cycles a grant is held (used only under REQ-025).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port req, input, req_width bits: level request per requester.
REQ-007 SHALL have port grant, output, req_width bits: one-hot grant, all-zero when nothing is granted.
REQ-008 SHALL have port grant_v, output, 1 bit: high when any grant is active.
REQ-009 SHALL have port grant_enc, output, enc_width bits: binary index of the granted requester, valid when grant_v=1.

Function
REQ-010 SHALL implement a two-state FSM with states IDLE and HOLD.
REQ-011 In IDLE with req nonzero, SHALL select the first set req bit at or above ptr, scanning upward and wrapping modulo req_width, and enter HOLD on the next edge.
REQ-012 Latency SHALL be exactly one cycle: a req sampled in IDLE at edge N gives grant, grant_v and grant_enc by edge N+1.
REQ-013 In IDLE with req all-zero, SHALL remain in IDLE with all outputs zero.
REQ-014 In HOLD, SHALL keep grant and grant_enc constant while req[grant_enc]=1, whatever the other req bits do.
REQ-015 In HOLD with req[grant_enc]=0, SHALL return to IDLE on the next edge, clear the outputs, and set ptr to (grant_enc+1) mod req_width.
REQ-016 SHALL insert exactly one IDLE cycle, with grant_v=0, between consecutive grants, including when the same requester re-requests.
REQ-017 grant SHALL always equal the one-hot decode of grant_enc gated by grant_v; grant SHALL never have more than one bit set.
REQ-018 ptr wrap: when req_width is not a power of two, ptr SHALL wrap from req_width-1 to 0, and indices >= req_width SHALL never be granted.
REQ-019 A requester that drops req while not granted SHALL lose no state; there SHALL be no queued-request memory.

Reset
REQ-020 Asserting reset at any time, including mid-HOLD, SHALL immediately force the FSM to IDLE, ptr to 0, and grant, grant_v and grant_enc to 0, with no clock required.
REQ-021 The first arbitration after reset deassertion SHALL favour requester 0.

Configuration
REQ-022 Macro BASE_RR_ARB_TIMEOUT_EN SHALL enable grant-hold timeout logic.
REQ-023 Without the macro, SHALL have no timeout counter and no timeout port; HOLD SHALL last until req drops (REQ-015).
REQ-024 With the macro, SHALL add port timeout, output, 1 bit, reset value 0.
REQ-025 With the macro, a hold counter SHALL count HOLD cycles. After timeout_cycles cycles of grant_v=1, SHALL force a return to IDLE (as in REQ-015) and pulse timeout high for exactly one cycle, coincident with the first IDLE cycle.
REQ-026 With the macro, the counter SHALL clear on entry to HOLD and on reset, and SHALL be wide enough for timeout_cycles.

Structure
REQ-027 FSM state enum (IDLE, HOLD) SHALL live in shared package base_arb_pkg.
REQ-028 The one-hot decode of grant_enc SHALL be a sub-module, base_rr_onehot, with inputs en and index and a one-hot output.
REQ-029 The rotating priority search SHALL be combinational within base_rr_arb; only the FSM state, ptr, grant_enc, grant_v and the counter SHALL be registered.

Verification
REQ-030 Reset, then req=4'b0110 -> grant=4'b0010, grant_enc=1 one cycle later; drop req[1] -> one idle cycle, then grant=4'b0100.
REQ-031 req=4'b1111 held steady, each grantee drops after 2 cycles and re-raises -> grant order 0,1,2,3,0, with one grant_v=0 cycle between grants.
REQ-032 During HOLD of requester 2, toggle req[0] and req[3] -> grant stays 4'b0100 and grant_enc stays 2.
REQ-033 Assert reset asynchronously mid-HOLD -> outputs 0 before the next clk edge; after release with req=4'b1000 -> grant_enc=3.
REQ-034 With req_width=3 and enc_width=2, grant 2 then release with req=3'b011 -> grant_enc=0 (wrap), and index 3 is never seen.
REQ-035 With BASE_RR_ARB_TIMEOUT_EN, timeout_cycles=4, req[1] held high -> grant_v high for 4 cycles, timeout pulses once, and grant 1 is reissued after the idle cycle.
